// File: rtl/fmul_rr_arbiter_if.sv
// Bundle between the FMUL arbiter, its requesters, the shared FMUL datapath and the result consumer.
// The slave view is the arbiter; the master view is everything around it.
interface fmul_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic                mul_a_sign;
  logic [7:0]          mul_a_exp;
  logic [22:0]         mul_a_frac;
  logic                mul_b_sign;
  logic [7:0]          mul_b_exp;
  logic [22:0]         mul_b_frac;
  logic                mul_sign;
  logic [7:0]          mul_exp;
  logic [23:0]         mul_frac;
  logic                mul_error;
  logic                mul_overflow;
  logic                resp_valid;
  logic                resp_ready;
  logic [ID_W-1:0]     resp_id;
  logic [31:0]         resp_result;
  logic                resp_error;
  logic                resp_overflow;
  logic                busy;
  logic [15:0]         op_count;

  modport slave (
    input  req_valid, req_a, req_b,
    input  mul_sign, mul_exp, mul_frac, mul_error, mul_overflow,
    input  resp_ready,
    output req_ready,
    output mul_a_sign, mul_a_exp, mul_a_frac, mul_b_sign, mul_b_exp, mul_b_frac,
    output resp_valid, resp_id, resp_result, resp_error, resp_overflow,
    output busy, op_count
  );

  modport master (
    output req_valid, req_a, req_b,
    output mul_sign, mul_exp, mul_frac, mul_error, mul_overflow,
    output resp_ready,
    input  req_ready,
    input  mul_a_sign, mul_a_exp, mul_a_frac, mul_b_sign, mul_b_exp, mul_b_frac,
    input  resp_valid, resp_id, resp_result, resp_error, resp_overflow,
    input  busy, op_count
  );
endinterface

// File: rtl/fmul_rr_arbiter.sv
// Round-robin arbiter sharing one combinational FMUL among N_REQ requesters,
// with one operation in flight: accept -> settle wait -> response handshake.
module fmul_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  fmul_rr_arbiter_if.slave   bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      res_q, res_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             rv_q, rv_d;
  logic [15:0]      ops_q, ops_d;

  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] grant_next;
  logic             found;
  logic [IDX_W:0]   idx;
  logic [N_REQ-1:0] req_ready_c;
  logic             unused_hidden_bit;

  // Rotating priority: scan upward from ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(N_REQ)) begin
        idx = idx - (IDX_W+1)'(N_REQ);
      end
      if (!found && bus.req_valid[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        grant = idx[IDX_W-1:0];
      end
    end
  end

  assign grant_next = (grant == IDX_W'(N_REQ-1)) ? '0 : grant + IDX_W'(1);

  always_comb begin
    req_ready_c = '0;
    if (state_q == IDLE && found) begin
      req_ready_c[grant] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    rv_d    = rv_q;
    ops_d   = ops_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          a_d     = bus.req_a[{grant, 5'b0} +: 32];
          b_d     = bus.req_b[{grant, 5'b0} +: 32];
          id_d    = ID_W'(grant);
          ptr_d   = grant_next;
          cnt_d   = 4'(MUL_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Operands sit unchanged in a_q/b_q while the FMUL settles.
        if (cnt_q == 4'd0) begin
          res_d   = {bus.mul_sign, bus.mul_exp, bus.mul_frac[22:0]};
          err_d   = bus.mul_error;
          ovf_d   = bus.mul_overflow;
          rv_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          rv_d    = 1'b0;
          ops_d   = ops_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      rv_q    <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      rv_q    <= rv_d;
      ops_q   <= ops_d;
    end
  end

  // The hidden bit is implied by the exponent, so only frac[22:0] is forwarded.
  assign unused_hidden_bit = bus.mul_frac[23];

  assign bus.req_ready     = req_ready_c;
  assign bus.mul_a_sign    = a_q[31];
  assign bus.mul_a_exp     = a_q[30:23];
  assign bus.mul_a_frac    = a_q[22:0];
  assign bus.mul_b_sign    = b_q[31];
  assign bus.mul_b_exp     = b_q[30:23];
  assign bus.mul_b_frac    = b_q[22:0];
  assign bus.resp_valid    = rv_q;
  assign bus.resp_id       = id_q;
  assign bus.resp_result   = res_q;
  assign bus.resp_error    = err_q;
  assign bus.resp_overflow = ovf_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.op_count      = ops_q;

endmodule

// File: tb/tb_fmul_rr_arbiter.sv
// Directed bench for fmul_rr_arbiter: a behavioural FMUL, a vector table of
// single operations, and hand-written round-robin, backpressure and reset sequences.
module tb_fmul_rr_arbiter;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   exp_ops = 0;

  always #5 clk = ~clk;

  fmul_rr_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  fmul_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural single-precision multiplier (truncating, denormals as zero).
  logic [47:0] prod;
  int          e;
  logic        a_inf, b_inf, a_zero, b_zero, a_nan, b_nan;
  always_comb begin
    bus.mul_sign     = bus.mul_a_sign ^ bus.mul_b_sign;
    bus.mul_exp      = 8'h00;
    bus.mul_frac     = 24'h0;
    bus.mul_error    = 1'b0;
    bus.mul_overflow = 1'b0;
    a_inf  = (bus.mul_a_exp == 8'hFF) && (bus.mul_a_frac == 23'h0);
    b_inf  = (bus.mul_b_exp == 8'hFF) && (bus.mul_b_frac == 23'h0);
    a_nan  = (bus.mul_a_exp == 8'hFF) && (bus.mul_a_frac != 23'h0);
    b_nan  = (bus.mul_b_exp == 8'hFF) && (bus.mul_b_frac != 23'h0);
    a_zero = (bus.mul_a_exp == 8'h00);
    b_zero = (bus.mul_b_exp == 8'h00);
    prod   = {24'h0, 1'b1, bus.mul_a_frac} * {24'h0, 1'b1, bus.mul_b_frac};
    e      = int'(bus.mul_a_exp) + int'(bus.mul_b_exp) - 127;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      bus.mul_error = 1'b1;
      bus.mul_exp   = 8'hFF;
      bus.mul_frac  = 24'hC00000;
    end else if (a_inf || b_inf) begin
      bus.mul_exp = 8'hFF;
    end else if (a_zero || b_zero) begin
      bus.mul_exp = 8'h00;
    end else begin
      if (prod[47]) begin
        e = e + 1;
        bus.mul_frac = prod[47:24];
      end else begin
        bus.mul_frac = prod[46:23];
      end
      if (e >= 255) begin
        bus.mul_overflow = 1'b1;
        bus.mul_exp      = 8'hFF;
        bus.mul_frac     = 24'h0;
      end else if (e <= 0) begin
        bus.mul_exp  = 8'h00;
        bus.mul_frac = 24'h0;
      end else begin
        bus.mul_exp = 8'(e);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*r +: 32] = a;
    bus.req_b[32*r +: 32] = b;
  endtask

  task automatic wait_resp(inout int lat);
    while (!bus.resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // One operation from requester r with resp_ready held high.
  task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic err, input logic ovf,
                        input string nm);
    int lat;
    @(negedge clk);
    set_req(r, a, b);
    bus.req_valid = 4'(1 << r);
    #1 chk({nm, "_req_ready"}, 64'(bus.req_ready), 64'(1 << r));
    @(negedge clk);
    bus.req_valid = '0;
    lat = 1;
    chk({nm, "_busy"}, 64'(bus.busy), 64'd1);
    chk({nm, "_opa"}, {bus.mul_a_sign, bus.mul_a_exp, bus.mul_a_frac}, 64'(a));
    chk({nm, "_opb"}, {bus.mul_b_sign, bus.mul_b_exp, bus.mul_b_frac}, 64'(b));
    wait_resp(lat);
    chk({nm, "_latency"}, 64'(lat), 64'(1 + MUL_LAT));
    chk({nm, "_result"}, 64'(bus.resp_result), 64'(res));
    chk({nm, "_id"}, 64'(bus.resp_id), 64'(r));
    chk({nm, "_error"}, 64'(bus.resp_error), 64'(err));
    chk({nm, "_overflow"}, 64'(bus.resp_overflow), 64'(ovf));
    @(negedge clk);
    exp_ops++;
    chk({nm, "_valid_drop"}, 64'(bus.resp_valid), 64'd0);
    chk({nm, "_idle"}, 64'(bus.busy), 64'd0);
    chk({nm, "_op_count"}, 64'(bus.op_count), 64'(exp_ops));
    chk({nm, "_opa_hold"}, {bus.mul_a_sign, bus.mul_a_exp, bus.mul_a_frac}, 64'(a));
  endtask

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    logic        ovf;
  } vec_t;

  vec_t        tbl[5];
  logic [31:0] rr_b[4];
  logic [31:0] rr_res[4];

  initial begin
    int          k;
    int          lat;
    logic        saw_valid;

    tbl[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0};
    tbl[1] = '{1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0};
    tbl[2] = '{2, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0, 1'b1};
    tbl[3] = '{1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0};
    tbl[4] = '{3, 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0};
    rr_b   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    rr_res = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_op_count", 64'(bus.op_count), 64'd0);
    chk("rst_opa", {bus.mul_a_sign, bus.mul_a_exp, bus.mul_a_frac}, 64'd0);
    chk("rst_result", 64'(bus.resp_result), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].err, tbl[i].ovf,
             $sformatf("vec%0d", i));
    end

    // All four requesters held valid: grants rotate 0,1,2,3,0.
    @(negedge clk);
    for (int r = 0; r < N_REQ; r++) set_req(r, 32'h40000000, rr_b[r]);
    bus.req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      k = 0;
      #1;
      while (bus.req_ready == '0 && k < 40) begin
        @(negedge clk);
        #1;
        k++;
      end
      chk($sformatf("rr%0d_grant", g), 64'(bus.req_ready), 64'(1 << (g % 4)));
      @(negedge clk);
      lat = 1;
      wait_resp(lat);
      chk($sformatf("rr%0d_id", g), 64'(bus.resp_id), 64'(g % 4));
      chk($sformatf("rr%0d_result", g), 64'(bus.resp_result), 64'(rr_res[g % 4]));
      @(negedge clk);
      exp_ops++;
    end
    bus.req_valid = '0;
    chk("rr_op_count", 64'(bus.op_count), 64'(exp_ops));

    // Consumer stalls for five cycles with other requesters pending.
    bus.resp_ready = 1'b0;
    @(negedge clk);
    set_req(2, 32'h3FC00000, 32'h3FC00000);
    bus.req_valid = 4'b0100;
    #1 chk("bp_accept", 64'(bus.req_ready), 64'b0100);
    @(negedge clk);
    bus.req_valid = 4'b1011;
    lat = 1;
    wait_resp(lat);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), 64'(bus.resp_valid), 64'd1);
      chk($sformatf("bp%0d_result", i), 64'(bus.resp_result), 64'h40100000);
      chk($sformatf("bp%0d_id", i), 64'(bus.resp_id), 64'd2);
      chk($sformatf("bp%0d_req_ready", i), 64'(bus.req_ready), 64'd0);
      chk($sformatf("bp%0d_busy", i), 64'(bus.busy), 64'd1);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    bus.req_valid  = '0;
    @(negedge clk);
    exp_ops++;
    chk("bp_release_valid", 64'(bus.resp_valid), 64'd0);
    chk("bp_release_busy", 64'(bus.busy), 64'd0);
    chk("bp_op_count", 64'(bus.op_count), 64'(exp_ops));
    @(negedge clk);
    chk("bp_op_count_once", 64'(bus.op_count), 64'(exp_ops));

    // Reset while an op from requester 1 is waiting (ptr would otherwise be 2).
    set_req(1, 32'h40000000, 32'h40400000);
    bus.req_valid = 4'b0010;
    #1 chk("rw_accept", 64'(bus.req_ready), 64'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    exp_ops = 0;
    chk("rw_busy", 64'(bus.busy), 64'd0);
    chk("rw_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rw_op_count", 64'(bus.op_count), 64'd0);
    chk("rw_opa", {bus.mul_a_sign, bus.mul_a_exp, bus.mul_a_frac}, 64'd0);
    chk("rw_opb", {bus.mul_b_sign, bus.mul_b_exp, bus.mul_b_frac}, 64'd0);
    chk("rw_result", 64'(bus.resp_result), 64'd0);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      saw_valid = saw_valid | bus.resp_valid;
    end
    chk("rw_no_response", 64'(saw_valid), 64'd0);
    set_req(1, 32'h40000000, 32'h40000000);
    set_req(2, 32'h40000000, 32'h40400000);
    bus.req_valid = 4'b0110;
    #1 chk("rw_grant_after_reset", 64'(bus.req_ready), 64'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    lat = 1;
    wait_resp(lat);
    chk("rw_id", 64'(bus.resp_id), 64'd1);
    chk("rw_result2", 64'(bus.resp_result), 64'h40800000);
    @(negedge clk);
    exp_ops++;
    chk("rw_op_count2", 64'(bus.op_count), 64'(exp_ops));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
